core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the NPC core datapath. It steps the fetch, decode, execute, memory and writeback stages in turn, and issues stage enables and memory request/acknowledge handshakes. It sits above IFU/IDU/EXU/LSU/WBU and is their only source of enables, register-file write strobes and PC update strobes. It also detects ebreak, illegal instructions and memory hangs, and parks the core in a halt state.

Parameters:
TIMEOUT_W, 8, watchdog counter width; a wait of 2^TIMEOUT_W-1 cycles in FETCH or MEM is a timeout.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ifu_rvalid  input  1  instruction memory response valid
lsu_ack  input  1  data memory access complete
dec_load  input  1  decoded instruction is a load
dec_store  input  1  decoded instruction is a store
dec_rf_wr  input  1  decoded instruction writes rd
dec_ebreak  input  1  decoded instruction is ebreak
dec_illegal  input  1  opcode not recognised
ifu_req  output  1  instruction fetch request, held until ifu_rvalid
inst_we  output  1  latch the fetched instruction
idu_en  output  1  decode stage enable
exu_en  output  1  execute stage enable
lsu_req  output  1  data memory request, held until lsu_ack
lsu_we  output  1  data memory write (store)
rf_wen  output  1  register-file write strobe
pc_wen  output  1  PC update strobe
retire  output  1  one-cycle pulse per completed instruction
halted  output  1  core halted (sticky)
halt_code  output  2  0 = ebreak, 1 = illegal, 2 = timeout, 3 = reserved
perf_cycles  output  32  cycle counter (optional feature)
perf_instret  output  32  retired-instruction counter (optional feature)

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk. Reset puts the state in FETCH and clears the watchdog.
- Reset values: all outputs 0, halt_code 0. ifu_req rises in the first cycle after rst deasserts.
- Reset mid-operation: aborts any outstanding request. ifu_req/lsu_req drop at the reset edge, and late acks are ignored.
- State machine (one-hot or binary, designer's choice): FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - ifu_req=1.
  - On ifu_rvalid: inst_we=1 in that same cycle (combinational from state & ifu_rvalid), then go to DECODE.
- DECODE: idu_en=1 for exactly one cycle, then go to EXEC.
- EXEC: exu_en=1 for one cycle. dec_* are sampled here; they must be stable from DECODE onward. Transition priority:
  1. dec_illegal: go to HALT, halt_code=1.
  2. dec_ebreak: go to HALT, halt_code=0.
  3. dec_load or dec_store: go to MEM.
  4. Otherwise: go to WB.
- MEM:
  - lsu_req=1 and lsu_we=dec_store, held until lsu_ack.
  - On lsu_ack: go to WB.
- WB:
  - rf_wen = dec_rf_wr & ~dec_store.
  - pc_wen=1 and retire=1, each for one cycle.
  - Then go to FETCH.
- Latency: 4 cycles per ALU instruction and 5 per load/store with zero-wait memory (rvalid/ack in the first request cycle).
- HALT:
  - halted=1 and all enables/requests 0.
  - Held until rst.
- Watchdog:
  - Clears on entry to FETCH or MEM and increments each waiting cycle.
  - On reaching all-ones without a response: go to HALT, halt_code=2.
  - If the response and expiry coincide, the response wins.
- ifu_rvalid outside FETCH and lsu_ack outside MEM are ignored.
- Enables (other than inst_we) are Moore outputs decoded from the state register, with no combinational path from the inputs.

Optional Feature:
PERF_CNT_EN
- Defined:
  - perf_cycles increments every cycle the core is out of reset and not halted.
  - perf_instret increments on retire.
  - Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Undefined: both ports remain present and are driven constant 0, and no counter flops are built.

Test Plan:
1. Release reset, ifu_rvalid at cycle 1, dec all 0 except dec_rf_wr=1 -> inst_we@1, idu_en@2, exu_en@3, rf_wen/pc_wen/retire@4, ifu_req again @5.
2. Load with lsu_ack delayed 3 cycles -> lsu_req high 4 cycles with lsu_we=0, then WB with rf_wen=1; 8 cycles fetch-to-fetch.
3. Store, ack in first MEM cycle -> lsu_we=1 while lsu_req=1; WB has rf_wen=0, pc_wen=1.
4. dec_ebreak=1 -> halted=1, halt_code=0 one cycle after EXEC; no retire; spurious ifu_rvalid pulses are ignored. Repeat with dec_illegal=1 and dec_ebreak=1 together -> halt_code=1.
5. TIMEOUT_W=4, ifu_rvalid never asserted -> HALT with halt_code=2 after 15 FETCH cycles; repeat with rvalid on the 15th cycle -> DECODE, no halt.
6. PERF_CNT_EN defined, run 10 ALU instructions, then assert rst mid-MEM -> perf_instret=10 before reset; after reset all counters, halted and lsu_req are 0.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with halt detection and a request watchdog.
// Optional PERF_CNT_EN macro builds the cycle and retired-instruction counters.
module core_seq_ctrl #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_rvalid_i,
  input  logic        lsu_ack_i,
  input  logic        dec_load_i,
  input  logic        dec_store_i,
  input  logic        dec_rf_wr_i,
  input  logic        dec_ebreak_i,
  input  logic        dec_illegal_i,
  output logic        ifu_req_o,
  output logic        inst_we_o,
  output logic        idu_en_o,
  output logic        exu_en_o,
  output logic        lsu_req_o,
  output logic        lsu_we_o,
  output logic        rf_wen_o,
  output logic        pc_wen_o,
  output logic        retire_o,
  output logic        halted_o,
  output logic [1:0]  halt_code_o,
  output logic [31:0] perf_cycles_o,
  output logic [31:0] perf_instret_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [1:0] CODE_EBREAK  = 2'd0;
  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;

  // The count holds the number of cycles already waited, so the final
  // permitted waiting cycle is the one where the count is all-ones minus one.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~TIMEOUT_W'(1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] wdogCnt_q, wdogCnt_d;
  logic [1:0]           haltCode_q, haltCode_d;
  logic                 wdogExpire;

  assign wdogExpire = (wdogCnt_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wdogCnt_q  <= '0;
      haltCode_q <= CODE_EBREAK;
    end else begin
      state_q    <= state_d;
      wdogCnt_q  <= wdogCnt_d;
      haltCode_q <= haltCode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wdogCnt_d  = wdogCnt_q;
    haltCode_d = haltCode_q;
    case (state_q)
      S_FETCH: begin
        if (ifu_rvalid_i) begin
          state_d = S_DECODE;
        end else if (wdogExpire) begin
          state_d    = S_HALT;
          haltCode_d = CODE_TIMEOUT;
        end else begin
          wdogCnt_d = wdogCnt_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (dec_illegal_i) begin
          state_d    = S_HALT;
          haltCode_d = CODE_ILLEGAL;
        end else if (dec_ebreak_i) begin
          state_d    = S_HALT;
          haltCode_d = CODE_EBREAK;
        end else if (dec_load_i || dec_store_i) begin
          state_d   = S_MEM;
          wdogCnt_d = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (lsu_ack_i) begin
          state_d = S_WB;
        end else if (wdogExpire) begin
          state_d    = S_HALT;
          haltCode_d = CODE_TIMEOUT;
        end else begin
          wdogCnt_d = wdogCnt_q + 1'b1;
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        wdogCnt_d = '0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs are held low while rst is high so a reset aborts requests immediately.
  always_comb begin
    ifu_req_o   = 1'b0;
    inst_we_o   = 1'b0;
    idu_en_o    = 1'b0;
    exu_en_o    = 1'b0;
    lsu_req_o   = 1'b0;
    lsu_we_o    = 1'b0;
    rf_wen_o    = 1'b0;
    pc_wen_o    = 1'b0;
    retire_o    = 1'b0;
    halted_o    = 1'b0;
    halt_code_o = 2'd0;
    if (!rst) begin
      halt_code_o = haltCode_q;
      case (state_q)
        S_FETCH: begin
          ifu_req_o = 1'b1;
          inst_we_o = ifu_rvalid_i;
        end
        S_DECODE: idu_en_o = 1'b1;
        S_EXEC:   exu_en_o = 1'b1;
        S_MEM: begin
          lsu_req_o = 1'b1;
          lsu_we_o  = dec_store_i;
        end
        S_WB: begin
          rf_wen_o = dec_rf_wr_i & ~dec_store_i;
          pc_wen_o = 1'b1;
          retire_o = 1'b1;
        end
        S_HALT:  halted_o = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perfCycles_q, perfInstret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perfCycles_q  <= '0;
      perfInstret_q <= '0;
    end else begin
      if (state_q != S_HALT) perfCycles_q <= perfCycles_q + 32'd1;
      if (state_q == S_WB) perfInstret_q <= perfInstret_q + 32'd1;
    end
  end

  assign perf_cycles_o  = perfCycles_q;
  assign perf_instret_o = perfInstret_q;
`else
  assign perf_cycles_o  = 32'd0;
  assign perf_instret_o = 32'd0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Table-driven bench for core_seq_ctrl built with a 4-bit watchdog (15-cycle timeout).
// Counter expectations follow whether PERF_CNT_EN is defined for the build.
module tb_core_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_rvalid = 1'b0, lsu_ack = 1'b0;
  logic        dec_load = 1'b0, dec_store = 1'b0, dec_rf_wr = 1'b0;
  logic        dec_ebreak = 1'b0, dec_illegal = 1'b0;
  logic        ifu_req, inst_we, idu_en, exu_en, lsu_req, lsu_we;
  logic        rf_wen, pc_wen, retire, halted;
  logic [1:0]  halt_code;
  logic [31:0] perf_cycles, perf_instret;

  always #5 clk = ~clk;

  core_seq_ctrl #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_rvalid_i(ifu_rvalid), .lsu_ack_i(lsu_ack),
    .dec_load_i(dec_load), .dec_store_i(dec_store), .dec_rf_wr_i(dec_rf_wr),
    .dec_ebreak_i(dec_ebreak), .dec_illegal_i(dec_illegal),
    .ifu_req_o(ifu_req), .inst_we_o(inst_we), .idu_en_o(idu_en), .exu_en_o(exu_en),
    .lsu_req_o(lsu_req), .lsu_we_o(lsu_we), .rf_wen_o(rf_wen), .pc_wen_o(pc_wen),
    .retire_o(retire), .halted_o(halted), .halt_code_o(halt_code),
    .perf_cycles_o(perf_cycles), .perf_instret_o(perf_instret)
  );

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Decoded-instruction flags {load, store, rf_wr, ebreak, illegal}
  localparam logic [4:0] D_LOAD = 5'b10000, D_STORE = 5'b01000, D_RFWR = 5'b00100;
  localparam logic [4:0] D_EBRK = 5'b00010, D_ILL = 5'b00001;
  // Output vector {ifu_req, inst_we, idu_en, exu_en, lsu_req, lsu_we, rf_wen, pc_wen, retire, halted}
  localparam logic [9:0] O_REQ = 10'b1000000000, O_IWE = 10'b0100000000;
  localparam logic [9:0] O_IDU = 10'b0010000000, O_EXU = 10'b0001000000;
  localparam logic [9:0] O_LREQ = 10'b0000100000, O_LWE = 10'b0000010000;
  localparam logic [9:0] O_RFW = 10'b0000001000, O_PCW = 10'b0000000100;
  localparam logic [9:0] O_RET = 10'b0000000010, O_HLT = 10'b0000000001;
  localparam logic [9:0] O_NONE = 10'b0;

  typedef struct {
    logic       rvalid;
    logic       ack;
    logic [4:0] dec;
    logic [9:0] expOut;
    logic [1:0] expCode;
  } vec_t;

  vec_t vecs[$];
  int   vecCount  = 0;
  int   missCount = 0;

  task automatic addRow(input logic rv, input logic ak, input logic [4:0] d,
                        input logic [9:0] eo, input logic [1:0] ec);
    vec_t v;
    v.rvalid = rv; v.ack = ak; v.dec = d; v.expOut = eo; v.expCode = ec;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    ifu_rvalid = v.rvalid;
    lsu_ack    = v.ack;
    {dec_load, dec_store, dec_rf_wr, dec_ebreak, dec_illegal} = v.dec;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] expOut, input logic [1:0] expCode);
    logic [9:0] act;
    @(negedge clk);
    act = {ifu_req, inst_we, idu_en, exu_en, lsu_req, lsu_we, rf_wen, pc_wen, retire, halted};
    vecCount++;
    if (act !== expOut || halt_code !== expCode) begin
      missCount++;
      $display("[TB] FAIL %s: outputs=%b code=%0d, expected outputs=%b code=%0d",
               name, act, halt_code, expOut, expCode);
    end
  endtask

  task automatic checkPerf(input string name, input logic [31:0] expCyc, input logic [31:0] expRet);
    vecCount++;
    if (perf_cycles !== expCyc || perf_instret !== expRet) begin
      missCount++;
      $display("[TB] FAIL %s: cycles=%0d instret=%0d, expected cycles=%0d instret=%0d",
               name, perf_cycles, perf_instret, expCyc, expRet);
    end
  endtask

  task automatic runTable(input string phase);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("%s row %0d", phase, i + 1), vecs[i].expOut, vecs[i].expCode);
    end
    vecs.delete();
  endtask

  // Two reset cycles; the second is checked after the reset edge has landed.
  task automatic doReset(input string name);
    @(posedge clk);
    #1;
    rst = 1'b1; ifu_rvalid = 1'b0; lsu_ack = 1'b0;
    {dec_load, dec_store, dec_rf_wr, dec_ebreak, dec_illegal} = 5'b0;
    @(posedge clk);
    checkOutput({name, " reset"}, O_NONE, 2'd0);
    checkPerf({name, " reset perf"}, 32'd0, 32'd0);
  endtask

  initial begin
    $display("[TB] core_seq_ctrl bench start, PERF=%0d", PERF);

    // ALU, delayed load, store with fetch waits, plain ALU, ebreak halt
    doReset("A");
    addRow(1, 0, D_RFWR, O_REQ | O_IWE, 0);
    addRow(1, 1, D_RFWR, O_IDU, 0);
    addRow(0, 1, D_RFWR, O_EXU, 0);
    addRow(0, 0, D_RFWR, O_RFW | O_PCW | O_RET, 0);
    addRow(1, 0, D_LOAD | D_RFWR, O_REQ | O_IWE, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_IDU, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_EXU, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_LREQ, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_LREQ, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_LREQ, 0);
    addRow(0, 1, D_LOAD | D_RFWR, O_LREQ, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_RFW | O_PCW | O_RET, 0);
    addRow(0, 0, D_STORE | D_RFWR, O_REQ, 0);
    addRow(0, 1, D_STORE | D_RFWR, O_REQ, 0);
    addRow(1, 0, D_STORE | D_RFWR, O_REQ | O_IWE, 0);
    addRow(0, 0, D_STORE | D_RFWR, O_IDU, 0);
    addRow(0, 0, D_STORE | D_RFWR, O_EXU, 0);
    addRow(0, 1, D_STORE | D_RFWR, O_LREQ | O_LWE, 0);
    addRow(0, 0, D_STORE | D_RFWR, O_PCW | O_RET, 0);
    addRow(1, 0, 5'b0, O_REQ | O_IWE, 0);
    addRow(0, 0, 5'b0, O_IDU, 0);
    addRow(0, 0, 5'b0, O_EXU, 0);
    addRow(0, 0, 5'b0, O_PCW | O_RET, 0);
    addRow(1, 0, D_EBRK, O_REQ | O_IWE, 0);
    addRow(0, 0, D_EBRK, O_IDU, 0);
    addRow(0, 0, D_EBRK, O_EXU, 0);
    addRow(1, 0, D_EBRK, O_HLT, 0);
    addRow(1, 1, D_EBRK, O_HLT, 0);
    addRow(1, 0, 5'b0, O_HLT, 0);
    runTable("A");

    // Illegal beats ebreak and load
    doReset("B");
    addRow(1, 0, D_ILL | D_EBRK | D_LOAD, O_REQ | O_IWE, 0);
    addRow(0, 0, D_ILL | D_EBRK | D_LOAD, O_IDU, 0);
    addRow(0, 0, D_ILL | D_EBRK | D_LOAD, O_EXU, 0);
    addRow(0, 1, D_ILL | D_EBRK | D_LOAD, O_HLT, 1);
    addRow(1, 0, D_ILL | D_EBRK | D_LOAD, O_HLT, 1);
    runTable("B");

    // Fetch timeout after 15 waiting cycles; cycle counter freezes in HALT
    doReset("C");
    for (int i = 0; i < 15; i++) addRow(0, 0, 5'b0, O_REQ, 0);
    addRow(0, 0, 5'b0, O_HLT, 2);
    addRow(1, 0, 5'b0, O_HLT, 2);
    runTable("C");
    checkPerf("C halted perf", PERF ? 32'd15 : 32'd0, 32'd0);

    // rvalid on the 15th cycle wins; watchdog restarts on the next fetch
    doReset("D");
    for (int i = 0; i < 14; i++) addRow(0, 0, D_RFWR, O_REQ, 0);
    addRow(1, 0, D_RFWR, O_REQ | O_IWE, 0);
    addRow(0, 0, D_RFWR, O_IDU, 0);
    addRow(0, 0, D_RFWR, O_EXU, 0);
    addRow(0, 0, D_RFWR, O_RFW | O_PCW | O_RET, 0);
    for (int i = 0; i < 15; i++) addRow(0, 0, 5'b0, O_REQ, 0);
    addRow(0, 0, 5'b0, O_HLT, 2);
    runTable("D");

    // Memory timeout after 15 unacknowledged MEM cycles
    doReset("E");
    addRow(1, 0, D_LOAD, O_REQ | O_IWE, 0);
    addRow(0, 0, D_LOAD, O_IDU, 0);
    addRow(0, 0, D_LOAD, O_EXU, 0);
    for (int i = 0; i < 15; i++) addRow(0, 0, D_LOAD, O_LREQ, 0);
    addRow(0, 1, D_LOAD, O_HLT, 2);
    runTable("E");

    // Ten ALU instructions, then reset in the middle of a load
    doReset("F");
    for (int i = 0; i < 10; i++) begin
      addRow(1, 0, D_RFWR, O_REQ | O_IWE, 0);
      addRow(0, 0, D_RFWR, O_IDU, 0);
      addRow(0, 0, D_RFWR, O_EXU, 0);
      addRow(0, 0, D_RFWR, O_RFW | O_PCW | O_RET, 0);
    end
    addRow(1, 0, D_LOAD | D_RFWR, O_REQ | O_IWE, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_IDU, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_EXU, 0);
    addRow(0, 0, D_LOAD | D_RFWR, O_LREQ, 0);
    runTable("F");
    checkPerf("F mid-MEM perf", PERF ? 32'd43 : 32'd0, PERF ? 32'd10 : 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    lsu_ack = 1'b1;
    checkOutput("F rst mid-MEM", O_NONE, 2'd0);
    addRow(0, 1, D_LOAD | D_RFWR, O_REQ, 0);
    addRow(1, 1, D_LOAD | D_RFWR, O_REQ | O_IWE, 0);
    runTable("F after reset");
    checkPerf("F after reset perf", PERF ? 32'd1 : 32'd0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
